dat_mem_p: RTL
==============

# dat_mem_p

Parametrised successor to the processor's data memory: a WIDTH-bit, DEPTH-word single-port array with combinational read and clocked write, extended with a hardware clear engine, out-of-range address protection and a saturating error counter. It sits between the datapath's load/store unit and the register file. The control unit must hold off memory accesses while `busy` is high, which covers the sweep after reset and any software-requested clear.

## Interface
- `WIDTH`, default 8: data word width in bits.
- `DEPTH`, default 256: number of words; 2 ≤ DEPTH ≤ 2**AW.
- `AW`, default 8: address width.
- `CLR_VAL`, default 0: WIDTH-bit value written by the clear engine.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `clr_req`  in  1  single-cycle request to sweep the whole array to CLR_VAL.
- `wr_en`  in  1  write enable.
- `addr`  in  AW  word address.
- `dat_in`  in  WIDTH  write data.
- `dat_out`  out  WIDTH  combinational read data.
- `busy`  out  1  clear sweep in progress.
- `oob`  out  1  combinational; high when addr ≥ DEPTH.
- `err_cnt`  out  8  saturating count of rejected writes.
- `par_err`  out  1  parity mismatch on the current read; present only with DAT_MEM_PARITY_EN.

## Operation
- Storage: `core[DEPTH]` of WIDTH bits. Memory contents are not touched while `reset` is high.
- FSM states: CLEAR and IDLE. Pointer `ptr` is AW bits wide.
- While `reset`=1: state=CLEAR, ptr=0, err_cnt=0.
- CLEAR, each edge with reset=0: core[ptr] <= CLR_VAL.
  - If ptr==DEPTH-1, go to IDLE.
  - Otherwise ptr <= ptr+1.
- IDLE, clr_req=1: next state CLEAR, ptr <= 0.
- clr_req while in CLEAR is ignored; the sweep does not restart.
- Writes in IDLE:
  - wr_en=1 and oob=0: core[addr] <= dat_in.
  - wr_en=1 and oob=1: write suppressed, err_cnt increments.
- Writes in CLEAR: wr_en=1 is suppressed and err_cnt increments, whatever the value of oob.
- err_cnt saturates at 255. Only reset clears it; clr_req does not.
- Read: dat_out = core[addr] when state=IDLE and oob=0. Otherwise dat_out = 0.
- busy = (state==CLEAR).

## Timing
- Reset values: busy=1, err_cnt=0, dat_out=0. oob is combinational on addr.
- Sweep duration: exactly DEPTH cycles after the first posedge with reset=0.
  - busy falls on the edge that writes word DEPTH-1.
  - The first access is accepted on the next edge.
- clr_req sampled in IDLE: busy=1 from the next edge, for DEPTH cycles.
- clr_req and wr_en in the same IDLE cycle: the write commits on that edge. The sweep then overwrites it with CLR_VAL.
- Read latency is zero (combinational). Write-to-read latency is one edge: new data is visible after the posedge.
- Reset asserted mid-sweep: the sweep aborts and restarts from ptr=0 once reset falls. Already-cleared words are rewritten.
- DEPTH < 2**AW: addresses DEPTH..2**AW-1 read 0 and are never written.

## Configuration
- `DAT_MEM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit, computed on write, including clear-engine writes.
  - par_err = 1 when state=IDLE, oob=0 and the stored bit ≠ ^core[addr] data bits.
  - par_err reset value is 0.
- `DAT_MEM_PARITY_EN` undefined:
  - No parity storage and no `par_err` port.
  - All other behaviour is identical.

## Test plan
- Release reset and count cycles until busy falls: the count must equal DEPTH (256). Then read addr 0, 0x7F and 0xFF: all must return 0x00.
- In IDLE, write 0xA5 to addr 0x10 and 0x3C to addr 0x11. Read back 0xA5 and 0x3C on the cycle after each write, while err_cnt stays 0.
- With DEPTH=200, write 0x55 to addr 0xC8: oob=1, dat_out=0, err_cnt=1, and addr 0x00 stays unchanged. Then 300 OOB writes must leave err_cnt saturated at 255.
- Fill addr 0x20 with 0x77, pulse clr_req, and hold wr_en=1 for 3 cycles during the sweep. Required: busy=1 for 256 cycles, err_cnt=3, and addr 0x20 reads 0x00 afterwards.
- Assert reset at ptr≈100 during the sweep and release it: busy must stay high a full 256 cycles from release, and err_cnt must read 0.
- With DAT_MEM_PARITY_EN: write 0x0F and read it back with par_err=0. Force-flip the stored bit 0 of that word hierarchically and check par_err=1 on the read.

Source files
------------

// File: rtl/dat_mem_p.sv
// dat_mem_p: WIDTH x DEPTH data memory with clear engine, OOB guard
// and saturating rejected-write counter. Optional parity: DAT_MEM_PARITY_EN.
//
// Ports:
//   clk      in   clock, all state updates on posedge
//   reset    in   synchronous active-high reset
//   clr_req  in   one-cycle request to sweep the array to CLR_VAL
//   wr_en    in   write enable
//   addr     in   [AW-1:0] word address
//   dat_in   in   [WIDTH-1:0] write data
//   dat_out  out  [WIDTH-1:0] combinational read data (0 when busy/oob)
//   busy     out  clear sweep in progress
//   oob      out  combinational, addr >= DEPTH
//   err_cnt  out  [7:0] saturating count of rejected writes
//   par_err  out  parity mismatch on current read (DAT_MEM_PARITY_EN only)
module dat_mem_p #(
    parameter int unsigned     WIDTH   = 8,
    parameter int unsigned     DEPTH   = 256,
    parameter int unsigned     AW      = 8,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_req,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] dat_in,
    output logic [WIDTH-1:0] dat_out,
    output logic             busy,
    output logic             oob,
`ifdef DAT_MEM_PARITY_EN
    output logic             par_err,
`endif
    output logic [7:0]       err_cnt
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    w_ptr_nxt;
    logic [7:0]       r_err_cnt;
    logic [WIDTH-1:0] r_core [DEPTH];

    logic             w_oob;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_addr;
    logic [WIDTH-1:0] w_mem_wdata;
    logic             w_err_inc;

    // Full-width compare so DEPTH == 2**AW never flags an address.
    assign w_oob = (32'(addr) >= DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_mem_we    = 1'b0;
        w_mem_addr  = addr;
        w_mem_wdata = dat_in;
        w_err_inc   = 1'b0;
        unique case (r_state)
            S_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_ptr;
                w_mem_wdata = CLR_VAL;
                // Every write is rejected while sweeping, in range or not.
                w_err_inc   = wr_en;
                if (r_ptr == LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            S_IDLE: begin
                w_mem_we  = wr_en & ~w_oob;
                w_err_inc = wr_en & w_oob;
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_ptr     <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_err_inc && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Array has no reset; contents are frozen while reset is held.
    always_ff @(posedge clk) begin
        if (!reset && w_mem_we) begin
            r_core[w_mem_addr] <= w_mem_wdata;
        end
    end

    logic w_rd_ok;
    assign w_rd_ok = (r_state == S_IDLE) && !w_oob;

    assign dat_out = w_rd_ok ? r_core[addr] : '0;
    assign busy    = (r_state == S_CLEAR);
    assign oob     = w_oob;
    assign err_cnt = r_err_cnt;

`ifdef DAT_MEM_PARITY_EN
    logic r_par [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset && w_mem_we) begin
            r_par[w_mem_addr] <= ^w_mem_wdata;
        end
    end

    assign par_err = w_rd_ok && (r_par[addr] != ^r_core[addr]);
`endif

endmodule
